// File: rtl/perf_cnt_bank_if.sv
// Control and read-port bundle for perf_cnt_bank.
// The snap strobe exists only when PERF_CNT_SNAPSHOT_EN is defined.
interface perf_cnt_bank_if #(
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 4
);
    localparam int NCH   = NUM_EVT + 1;
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NUM_EVT-1:0] evt_inc;
    logic [NCH-1:0]     str_cnt;
    logic               stp_cnt;
    logic               clr_cnt;
    logic [SEL_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   rd_data;
    logic [NCH-1:0]     ovf_flags;
    logic               cnt_active;
    logic [1:0]         bank_state;
`ifdef PERF_CNT_SNAPSHOT_EN
    logic               snap;
`endif

    modport master (
`ifdef PERF_CNT_SNAPSHOT_EN
        output snap,
`endif
        output evt_inc, str_cnt, stp_cnt, clr_cnt, rd_sel,
        input  rd_data, ovf_flags, cnt_active, bank_state
    );

    modport slave (
`ifdef PERF_CNT_SNAPSHOT_EN
        input  snap,
`endif
        input  evt_inc, str_cnt, stp_cnt, clr_cnt, rd_sel,
        output rd_data, ovf_flags, cnt_active, bank_state
    );
endinterface

// File: rtl/perf_cnt_bank.sv
// Performance-counter bank: channel 0 counts cycles, channels 1..NUM_EVT count event strobes.
// Define PERF_CNT_SNAPSHOT_EN to add a snap-loaded shadow bank that feeds rd_data/ovf_flags.
module perf_cnt_bank #(
    parameter int CNT_W    = 32,
    parameter int NUM_EVT  = 4,
    parameter int SAT_MODE = 0
) (
    input logic             clk,
    input logic             rst,
    perf_cnt_bank_if.slave  bus
);
    localparam int NCH   = NUM_EVT + 1;
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    logic [CNT_W-1:0] cnt     [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];
    logic [CNT_W:0]   bumped  [NCH];
    logic [NCH-1:0]   arm, arm_nxt;
    logic [NCH-1:0]   ovf, ovf_nxt;
    logic [NCH-1:0]   hit;
    logic [CNT_W-1:0] rd_src, rd_q;
    state_t           state, state_nxt;

    // Returns {overflow, next_count}; saturating builds hold at all-ones.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
        if (&v)
            return (SAT_MODE != 0) ? {1'b1, v} : {1'b1, {CNT_W{1'b0}}};
        return {1'b0, v + CNT_W'(1)};
    endfunction

    assign hit = {bus.evt_inc, 1'b1};

    always_comb begin
        for (int c = 0; c < NCH; c++) bumped[c] = bump(cnt[c]);
    end

    // Priority: clear beats stop beats start beats increment.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        arm_nxt = bus.stp_cnt ? '0 : (arm | bus.str_cnt);
        for (int c = 0; c < NCH; c++) begin
            if (bus.clr_cnt) begin
                cnt_nxt[c] = '0;
                ovf_nxt[c] = 1'b0;
            end else if (arm[c] && hit[c] && !bus.stp_cnt) begin
                cnt_nxt[c] = bumped[c][CNT_W-1:0];
                ovf_nxt[c] = ovf[c] | bumped[c][CNT_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.clr_cnt && arm_nxt == '0) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (|arm_nxt) state_nxt = RUN;
                RUN:     if (bus.stp_cnt) state_nxt = HALTED;
                HALTED:  if (|arm_nxt) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm   <= '0;
            ovf   <= '0;
            state <= IDLE;
            rd_q  <= '0;
            for (int c = 0; c < NCH; c++) cnt[c] <= '0;
        end else begin
            arm   <= arm_nxt;
            ovf   <= ovf_nxt;
            state <= state_nxt;
            rd_q  <= rd_src;
            for (int c = 0; c < NCH; c++) cnt[c] <= cnt_nxt[c];
        end
    end

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [CNT_W-1:0] shd [NCH];
    logic [NCH-1:0]   shd_ovf;

    // Shadow captures post-update values; clr_cnt leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_ovf <= '0;
            for (int c = 0; c < NCH; c++) shd[c] <= '0;
        end else if (bus.snap) begin
            shd_ovf <= ovf_nxt;
            for (int c = 0; c < NCH; c++) shd[c] <= cnt_nxt[c];
        end
    end

    always_comb begin
        rd_src = '0;
        for (int c = 0; c < NCH; c++)
            if (bus.rd_sel == SEL_W'(c)) rd_src = shd[c];
    end

    assign bus.ovf_flags = shd_ovf;
`else
    always_comb begin
        rd_src = '0;
        for (int c = 0; c < NCH; c++)
            if (bus.rd_sel == SEL_W'(c)) rd_src = cnt[c];
    end

    assign bus.ovf_flags = ovf;
`endif

    assign bus.rd_data    = rd_q;
    assign bus.cnt_active = |arm;
    assign bus.bank_state = state;
endmodule

// File: tb/tb_perf_cnt_bank.sv
// Bench for perf_cnt_bank: three instances (16-bit wrap, 4-bit wrap, 4-bit saturate) share
// one stimulus stream; a reference model feeds a scoreboard checked by a separate monitor.
module tb_perf_cnt_bank;
    localparam int NUM_EVT = 2;
    localparam int NCH     = NUM_EVT + 1;
    localparam int NI      = 3;
`ifdef PERF_CNT_SNAPSHOT_EN
    localparam bit SNAP_BUILD = 1'b1;
`else
    localparam bit SNAP_BUILD = 1'b0;
`endif
    // With snap held high the shadow path behaves exactly like the live path.
    localparam logic SNAP_DFLT = SNAP_BUILD;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_EVT-1:0] evt_inc = '0;
    logic [NCH-1:0]     str_cnt = '0;
    logic               stp_cnt = 1'b0;
    logic               clr_cnt = 1'b0;
    logic [1:0]         rd_sel  = '0;
    logic               snap    = 1'b0;
    int                 total = 0;
    int                 bad   = 0;

    always #5 clk = ~clk;

    perf_cnt_bank_if #(.CNT_W(16), .NUM_EVT(NUM_EVT)) ifa ();
    perf_cnt_bank_if #(.CNT_W(4),  .NUM_EVT(NUM_EVT)) ifb ();
    perf_cnt_bank_if #(.CNT_W(4),  .NUM_EVT(NUM_EVT)) ifc ();

    assign ifa.evt_inc = evt_inc;  assign ifb.evt_inc = evt_inc;  assign ifc.evt_inc = evt_inc;
    assign ifa.str_cnt = str_cnt;  assign ifb.str_cnt = str_cnt;  assign ifc.str_cnt = str_cnt;
    assign ifa.stp_cnt = stp_cnt;  assign ifb.stp_cnt = stp_cnt;  assign ifc.stp_cnt = stp_cnt;
    assign ifa.clr_cnt = clr_cnt;  assign ifb.clr_cnt = clr_cnt;  assign ifc.clr_cnt = clr_cnt;
    assign ifa.rd_sel  = rd_sel;   assign ifb.rd_sel  = rd_sel;   assign ifc.rd_sel  = rd_sel;
`ifdef PERF_CNT_SNAPSHOT_EN
    assign ifa.snap = snap;  assign ifb.snap = snap;  assign ifc.snap = snap;
`endif

    perf_cnt_bank #(.CNT_W(16), .NUM_EVT(NUM_EVT), .SAT_MODE(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    perf_cnt_bank #(.CNT_W(4),  .NUM_EVT(NUM_EVT), .SAT_MODE(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    perf_cnt_bank #(.CNT_W(4),  .NUM_EVT(NUM_EVT), .SAT_MODE(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct packed {
        logic [NI-1:0][15:0]    rd;
        logic [NI-1:0][NCH-1:0] ov;
        logic [1:0]             st;
        logic                   act;
    } exp_t;

    exp_t sbq[$];

    // Reference state: counts as plain integers, arm flags, shadow copy, bank state.
    int unsigned mcnt  [NI][NCH];
    bit          movf  [NI][NCH];
    int unsigned mshd  [NI][NCH];
    bit          mshov [NI][NCH];
    bit          marm  [NCH];
    logic [1:0]  mstate = 2'b00;

    function automatic int unsigned top_of(int k);
        return (k == 0) ? 32'd65535 : 32'd15;
    endfunction

    function automatic bit sat_of(int k);
        return (k == 2);
    endfunction

    task automatic model_step();
        exp_t           e;
        bit             any;
        logic [NCH-1:0] hitv;
        e    = '0;
        any  = 1'b0;
        hitv = {evt_inc, 1'b1};
        for (int k = 0; k < NI; k++)
            if (!rst && rd_sel < NCH)
                e.rd[k] = 16'(SNAP_BUILD ? mshd[k][rd_sel] : mcnt[k][rd_sel]);
        if (rst) begin
            for (int k = 0; k < NI; k++)
                for (int c = 0; c < NCH; c++) begin
                    mcnt[k][c] = 0; movf[k][c] = 0; mshd[k][c] = 0; mshov[k][c] = 0;
                end
            for (int c = 0; c < NCH; c++) marm[c] = 0;
            mstate = 2'b00;
        end else begin
            for (int k = 0; k < NI; k++)
                for (int c = 0; c < NCH; c++) begin
                    if (clr_cnt) begin
                        mcnt[k][c] = 0;
                        movf[k][c] = 0;
                    end else if (marm[c] && !stp_cnt && hitv[c]) begin
                        if (mcnt[k][c] == top_of(k)) begin
                            movf[k][c] = 1;
                            mcnt[k][c] = sat_of(k) ? top_of(k) : 0;
                        end else begin
                            mcnt[k][c] = mcnt[k][c] + 1;
                        end
                    end
                end
            for (int c = 0; c < NCH; c++) begin
                marm[c] = !stp_cnt && (marm[c] || str_cnt[c]);
                any |= marm[c];
            end
            if (clr_cnt && !any)                 mstate = 2'b00;
            else if (any)                        mstate = 2'b01;
            else if (stp_cnt && mstate != 2'b00) mstate = 2'b10;
            if (SNAP_BUILD && snap)
                for (int k = 0; k < NI; k++)
                    for (int c = 0; c < NCH; c++) begin
                        mshd[k][c]  = mcnt[k][c];
                        mshov[k][c] = movf[k][c];
                    end
        end
        for (int k = 0; k < NI; k++)
            for (int c = 0; c < NCH; c++)
                e.ov[k][c] = SNAP_BUILD ? mshov[k][c] : movf[k][c];
        e.st  = mstate;
        e.act = any;
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input int unsigned got, input int unsigned want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, got, want);
        end
    endtask

    task automatic cyc(input logic [1:0] e, input logic [2:0] s, input logic p, input logic c,
                       input logic [1:0] sel, input logic sn, input logic r);
        @(negedge clk);
        evt_inc = e; str_cnt = s; stp_cnt = p; clr_cnt = c;
        rd_sel  = sel; snap = sn; rst = r;
        model_step();
    endtask

    task automatic idle(input logic [1:0] sel);
        cyc(2'b00, 3'b000, 1'b0, 1'b0, sel, SNAP_DFLT, 1'b0);
    endtask

    // Monitor: every cycle the DUTs present a response, pop one expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_rd_a",  int'(ifa.rd_data),   int'(e.rd[0]));
                chk("sb_rd_b",  int'(ifb.rd_data),   int'(e.rd[1]));
                chk("sb_rd_c",  int'(ifc.rd_data),   int'(e.rd[2]));
                chk("sb_ovf_a", int'(ifa.ovf_flags), int'(e.ov[0]));
                chk("sb_ovf_b", int'(ifb.ovf_flags), int'(e.ov[1]));
                chk("sb_ovf_c", int'(ifc.ovf_flags), int'(e.ov[2]));
                chk("sb_state", int'(ifa.bank_state), int'(e.st));
                chk("sb_active", int'(ifa.cnt_active), int'(e.act));
            end
        end
    end

    initial begin
        int guard;
        cyc(2'b00, 3'b000, 1'b0, 1'b0, 2'd0, SNAP_DFLT, 1'b1);
        cyc(2'b00, 3'b000, 1'b0, 1'b0, 2'd0, SNAP_DFLT, 1'b1);

        // Events without any start are ignored.
        for (int i = 0; i < 4; i++)
            cyc(2'b11, 3'b000, 1'b0, 1'b0, 2'(i % 3), SNAP_DFLT, 1'b0);
        idle(2'd1);
        idle(2'd1);
        chk("t1_state", int'(ifa.bank_state), 0);
        chk("t1_active", int'(ifa.cnt_active), 0);
        chk("t1_rd_ch1", int'(ifa.rd_data), 0);

        // Cycle counter: start, five idle cycles, stop.
        cyc(2'b00, 3'b001, 1'b0, 1'b0, 2'd0, SNAP_DFLT, 1'b0);
        for (int i = 0; i < 5; i++) idle(2'd0);
        cyc(2'b00, 3'b000, 1'b1, 1'b0, 2'd0, SNAP_DFLT, 1'b0);
        idle(2'd0);
        chk("t2_rd_after_stop", int'(ifa.rd_data), 5);
        for (int i = 0; i < 3; i++) idle(2'd0);
        chk("t2_rd_held", int'(ifa.rd_data), 5);
        chk("t2_state_halted", int'(ifa.bank_state), 2);

        // Event channel 1 counts 12 strobes; channel 2 never started.
        cyc(2'b00, 3'b010, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        for (int i = 0; i < 10; i++) cyc(2'b11, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b10, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        for (int i = 0; i < 2; i++) cyc(2'b11, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b11, 3'b000, 1'b1, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        idle(2'd1);
        idle(2'd1);
        chk("t3_ch1", int'(ifa.rd_data), 12);
        idle(2'd2);
        idle(2'd2);
        chk("t3_ch2", int'(ifa.rd_data), 0);

        // 17 increments: 4-bit wrap gives 1, 4-bit saturate gives 15, both flag overflow.
        cyc(2'b00, 3'b000, 1'b0, 1'b1, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b00, 3'b010, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        for (int i = 0; i < 17; i++) cyc(2'b01, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b00, 3'b000, 1'b1, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        idle(2'd1);
        idle(2'd1);
        chk("t4_wrap_cnt", int'(ifb.rd_data), 1);
        chk("t4_wrap_ovf", int'(ifb.ovf_flags[1]), 1);
        chk("t4_sat_cnt", int'(ifc.rd_data), 15);
        chk("t4_sat_ovf", int'(ifc.ovf_flags[1]), 1);
        chk("t4_wide_cnt", int'(ifa.rd_data), 17);

        // Start and stop together: channel stays unarmed.
        cyc(2'b00, 3'b000, 1'b0, 1'b1, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b01, 3'b010, 1'b1, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b01, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b01, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        chk("t5_ss_active", int'(ifa.cnt_active), 0);
        chk("t5_ss_cnt", int'(ifa.rd_data), 0);

        // Clear during counting: 0 at that edge, 1 the next, overflow flags dropped.
        cyc(2'b00, 3'b010, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        for (int i = 0; i < 18; i++) cyc(2'b01, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b01, 3'b000, 1'b0, 1'b1, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b01, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        cyc(2'b01, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        chk("t5_clr_zero", int'(ifa.rd_data), 0);
        chk("t5_clr_ovf", int'(ifb.ovf_flags), 0);
        cyc(2'b00, 3'b000, 1'b0, 1'b0, 2'd1, SNAP_DFLT, 1'b0);
        chk("t5_clr_next", int'(ifa.rd_data), 1);
        chk("t5_clr_run", int'(ifa.bank_state), 1);

        // Reset in the middle of a run.
        cyc(2'b11, 3'b001, 1'b0, 1'b0, 2'd0, SNAP_DFLT, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b11, 3'b000, 1'b0, 1'b0, 2'd0, SNAP_DFLT, 1'b0);
        cyc(2'b11, 3'b000, 1'b0, 1'b0, 2'd0, SNAP_DFLT, 1'b1);
        idle(2'd0);
        chk("t5_rst_state", int'(ifa.bank_state), 0);
        chk("t5_rst_active", int'(ifa.cnt_active), 0);
        chk("t5_rst_rd", int'(ifa.rd_data), 0);
        chk("t5_rst_ovf", int'(ifb.ovf_flags), 0);
        idle(2'd0);
        chk("t5_rst_ch0", int'(ifa.rd_data), 0);

`ifdef PERF_CNT_SNAPSHOT_EN
        // Snapshot at count 7 freezes the read path while live counting continues.
        cyc(2'b00, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(2'b00, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(2'b00, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b00, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t6_snap_hold", int'(ifa.rd_data), 7);
        cyc(2'b00, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        cyc(2'b00, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(2'b00, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("t6_snap_after_clr", int'(ifa.rd_data), 7);
        chk("t6_snap_after_clr_b", int'(ifb.rd_data), 7);
`endif

        // Randomised traffic, including out-of-range selects and rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] s;
            logic [1:0] e, sel;
            s   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            e   = 2'($urandom);
            sel = 2'($urandom_range(0, 3));
            cyc(e, s, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, sel,
                $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        end
        idle(2'd0);

        guard = 0;
        while (sbq.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sbq.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d pending, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
